// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register that feeds the memory stage.
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [2:0]       id_alu_control,
    input  logic             id_alu_src,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm_ext,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             stall,
    input  logic             flush,
    output logic             pc_src,
    output logic [WIDTH-1:0] pc_target,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_illegal,
    output logic [WIDTH-1:0] ex_alu_result,
    output logic [WIDTH-1:0] ex_write_data,
    output logic [4:0]       ex_rd
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] rd2_fwd;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             illegal;
    logic             zero;

    // Path 10 reads our own EX/MEM register, so a stalled stage forwards the held value.
    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] reg_data,
                                                 input logic [WIDTH-1:0] ex_data,
                                                 input logic [WIDTH-1:0] wb_data);
        case (sel)
            2'b10:   return ex_data;
            2'b01:   return wb_data;
            default: return reg_data;
        endcase
    endfunction

    assign op_a    = fwd_mux(forward_a, id_rd1, ex_alu_result, wb_result);
    assign rd2_fwd = fwd_mux(forward_b, id_rd2, ex_alu_result, wb_result);
    assign op_b    = id_alu_src ? id_imm_ext : rd2_fwd;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        result  = '0;
        illegal = 1'b0;
        case (id_alu_control)
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default: illegal = 1'b1;
        endcase
    end

    assign zero      = (result == '0);
    assign pc_target = id_pc + id_imm_ext;
    assign pc_src    = rst_n & id_valid & ~stall & ~flush & ((id_branch & zero) | id_jump);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_alu_result <= '0;
            ex_write_data <= '0;
            ex_rd         <= '0;
        end else if (flush) begin
            // Bubble: only the control bits matter; data fields keep whatever they held.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write & id_valid;
            ex_illegal    <= illegal & id_valid;
            ex_alu_result <= result;
            ex_write_data <= rd2_fwd;
            ex_rd         <= id_rd;
        end
    end

endmodule
